// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the MIPS pipeline front end: primary opcode
//   constants, the bubble instruction word, the fetch FSM state type and
//   the immediate-extension decode used by the IF/ID stage.
package mips_pkg;

  // Primary opcode field IdInstr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Bubble inserted into IF/ID on flush/redirect (sll $0,$0,0)
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    DRAIN = 2'b10
  } fetch_state_e;

  // Logical immediates are zero-extended; everything else (bubble included)
  // is sign-extended.
  function automatic logic ext_type(input logic [5:0] opcode);
    logic v;
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: v = 1'b0;
      default:                          v = 1'b1;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// fetch_hold_buffer
//   One-entry skid register that parks a fetched word (and its PC+4) when the
//   IF/ID register cannot take it in the cycle it returns.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   i_load              capture i_instr/i_pc4, entry becomes valid
//   i_unload            entry consumed, becomes empty
//   i_clear             discard entry (wins over load/unload)
//   i_instr, i_pc4      word and its address+4 to park
//   o_valid, o_instr, o_pc4  parked entry
module fetch_hold_buffer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc4,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc4
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;

  // Entry storage; clear beats load beats unload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc4   <= 32'h0000_0000;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   MIPS fetch stage plus IF/ID pipeline register. Owns the PC, issues word
//   fetches over a request/ready handshake, and absorbs stalls, flushes and
//   branch redirects without losing or duplicating instructions.
// Ports:
//   CLK, RST_N                 clock, synchronous active-low reset
//   Stall, Flush               hazard unit hold / squash of IF/ID
//   BranchTaken, BranchTarget  redirect (target bits [1:0] forced to 0)
//   ImemReq, ImemAddr          fetch request and word address (= PC)
//   ImemReady, ImemRdata       same-cycle accept and instruction data
//   IdValid, IdInstr, IdPCPlus4  IF/ID register contents
//   Rs, Rt, Rd, Immediate, ExtendType  decode fields of IdInstr
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemRdata,
  output logic        IdValid,
  output logic [31:0] IdInstr,
  output logic [31:0] IdPCPlus4,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [15:0] Immediate,
  output logic        ExtendType
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_target;
  logic         r_id_valid;
  logic [31:0]  r_id_instr;
  logic [31:0]  r_id_pc4;

  fetch_state_e w_state_nxt;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  w_target_nxt;
  logic         w_id_valid_nxt;
  logic [31:0]  w_id_instr_nxt;
  logic [31:0]  w_id_pc4_nxt;
  logic         w_hold_load;
  logic         w_hold_unload;
  logic         w_hold_clear;
  logic         w_hold_valid;
  logic [31:0]  w_hold_instr;
  logic [31:0]  w_hold_pc4;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_target;
  logic         w_squash;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = BranchTarget & 32'hFFFF_FFFC;
  // Both a redirect and a flush turn IF/ID into a bubble, whatever the FSM chose.
  assign w_squash   = BranchTaken | Flush;

  fetch_hold_buffer u_hold (
    .clk      (CLK),
    .rst_n    (RST_N),
    .i_load   (w_hold_load),
    .i_unload (w_hold_unload),
    .i_clear  (w_hold_clear),
    .i_instr  (ImemRdata),
    .i_pc4    (w_pc_plus4),
    .o_valid  (w_hold_valid),
    .o_instr  (w_hold_instr),
    .o_pc4    (w_hold_pc4)
  );

  // Next-state, next-PC and IF/ID load decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_target_nxt   = r_target;
    w_id_valid_nxt = r_id_valid;
    w_id_instr_nxt = r_id_instr;
    w_id_pc4_nxt   = r_id_pc4;
    w_hold_load    = 1'b0;
    w_hold_unload  = 1'b0;
    w_hold_clear   = 1'b0;
    case (r_state)
      FETCH: begin
        if (BranchTaken) begin
          w_hold_clear = 1'b1;
          if (ImemReady) begin
            // Word returned this cycle is simply dropped.
            w_pc_nxt = w_target;
          end else begin
            // Request is in flight: keep the address stable until it lands.
            w_target_nxt = w_target;
            w_state_nxt  = DRAIN;
          end
        end else if (ImemReady) begin
          w_pc_nxt = w_pc_plus4;
          if (Stall || Flush) begin
            w_hold_load = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_id_valid_nxt = 1'b1;
            w_id_instr_nxt = ImemRdata;
            w_id_pc4_nxt   = w_pc_plus4;
          end
        end else begin
          w_state_nxt = FETCH;
        end
      end
      HOLD: begin
        if (BranchTaken) begin
          w_hold_clear = 1'b1;
          w_pc_nxt     = w_target;
          w_state_nxt  = FETCH;
        end else if (Stall || Flush) begin
          w_state_nxt = HOLD;
        end else begin
          w_hold_unload  = 1'b1;
          w_id_valid_nxt = w_hold_valid;
          w_id_instr_nxt = w_hold_instr;
          w_id_pc4_nxt   = w_hold_pc4;
          w_state_nxt    = FETCH;
        end
      end
      DRAIN: begin
        // A newer redirect replaces the saved target; the drain still completes.
        w_target_nxt = BranchTaken ? w_target : r_target;
        if (ImemReady) begin
          w_pc_nxt    = w_target_nxt;
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      default: begin
        w_state_nxt = FETCH;
        w_pc_nxt    = RESET_PC;
      end
    endcase
  end

  // State, PC, saved target and IF/ID registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_target   <= 32'h0000_0000;
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
      r_id_pc4   <= 32'h0000_0000;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_target   <= w_target_nxt;
      r_id_valid <= w_squash ? 1'b0          : w_id_valid_nxt;
      r_id_instr <= w_squash ? NOP_INSTR     : w_id_instr_nxt;
      r_id_pc4   <= w_squash ? 32'h0000_0000 : w_id_pc4_nxt;
    end
  end

  // Request side depends only on registered state.
  assign ImemReq    = (r_state != HOLD);
  assign ImemAddr   = r_pc;

  assign IdValid    = r_id_valid;
  assign IdInstr    = r_id_instr;
  assign IdPCPlus4  = r_id_pc4;
  assign Rs         = r_id_instr[25:21];
  assign Rt         = r_id_instr[20:16];
  assign Rd         = r_id_instr[15:11];
  assign Immediate  = r_id_instr[15:0];
  assign ExtendType = ext_type(r_id_instr[31:26]);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the fetch stage.
module tb_instruction_fetch;

  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        CLK = 1'b0;
  logic        RST_N, Stall, Flush, BranchTaken, ImemReady;
  logic [31:0] BranchTarget, ImemRdata;
  logic        ImemReq, IdValid, ExtendType;
  logic [31:0] ImemAddr, IdInstr, IdPCPlus4;
  logic [4:0]  Rs, Rt, Rd;
  logic [15:0] Immediate;

  always #5 CLK = ~CLK;

  instruction_fetch #(.RESET_PC(RPC)) dut (
    .CLK(CLK), .RST_N(RST_N), .Stall(Stall), .Flush(Flush),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemReady(ImemReady),
    .ImemRdata(ImemRdata), .IdValid(IdValid), .IdInstr(IdInstr),
    .IdPCPlus4(IdPCPlus4), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .Immediate(Immediate), .ExtendType(ExtendType)
  );

  int checks = 0;
  int failures = 0;

  // Model: PC, outstanding-redirect info, parked words, IF/ID contents.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_target = 32'h0;
  bit          m_drain = 1'b0;
  logic [63:0] m_held[$];
  bit          m_valid = 1'b0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pc4 = 32'h0;

  bit          chk_en = 1'b0;
  bit          use_force = 1'b0;
  logic [31:0] force_word = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic bit exp_ext(input logic [31:0] instr);
    logic [5:0] op;
    op = instr[31:26];
    return (op >= 6'h0C && op <= 6'h0F) ? 1'b0 : 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: present memory data, advance the model, step past the edge.
  task automatic cycle();
    logic [31:0] tgt, n_pc, n_target, n_instr, n_pc4;
    bit          n_drain, n_valid;
    logic [63:0] n_held[$];
    ImemRdata = use_force ? force_word : mem_word(ImemAddr);
    tgt = BranchTarget & 32'hFFFF_FFFC;
    n_pc = m_pc; n_target = m_target; n_drain = m_drain; n_held = m_held;
    n_valid = m_valid; n_instr = m_instr; n_pc4 = m_pc4;
    if (!RST_N) begin
      n_pc = RPC; n_target = 32'h0; n_drain = 1'b0; n_held.delete();
      n_valid = 1'b0; n_instr = 32'h0; n_pc4 = 32'h0;
    end else begin
      if (m_drain) begin
        if (BranchTaken) n_target = tgt;
        if (ImemReady) begin n_pc = n_target; n_drain = 1'b0; end
      end else if (m_held.size() != 0) begin
        if (BranchTaken) begin
          n_held.delete(); n_pc = tgt;
        end else if (!Flush && !Stall) begin
          {n_instr, n_pc4} = n_held.pop_front(); n_valid = 1'b1;
        end
      end else begin
        if (BranchTaken) begin
          if (ImemReady) n_pc = tgt;
          else begin n_drain = 1'b1; n_target = tgt; end
        end else if (ImemReady) begin
          n_pc = m_pc + 32'd4;
          if (Stall || Flush) n_held.push_back({ImemRdata, m_pc + 32'd4});
          else begin n_valid = 1'b1; n_instr = ImemRdata; n_pc4 = m_pc + 32'd4; end
        end
      end
      if (BranchTaken || Flush) begin n_valid = 1'b0; n_instr = 32'h0; end
    end
    @(posedge CLK);
    m_pc = n_pc; m_target = n_target; m_drain = n_drain; m_held = n_held;
    m_valid = n_valid; m_instr = n_instr; m_pc4 = n_pc4;
    #1;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("req", 32'(ImemReq), 32'(m_held.size() == 0));
      chk("addr", ImemAddr, m_pc);
      chk("valid", 32'(IdValid), 32'(m_valid));
      chk("instr", IdInstr, m_instr);
      if (m_valid) chk("pc4", IdPCPlus4, m_pc4);
      chk("rs", 32'(Rs), 32'(m_instr[25:21]));
      chk("rt", 32'(Rt), 32'(m_instr[20:16]));
      chk("rd", 32'(Rd), 32'(m_instr[15:11]));
      chk("imm", 32'(Immediate), 32'(m_instr[15:0]));
      chk("ext", 32'(ExtendType), 32'(exp_ext(m_instr)));
    end
  end

  initial begin
    RST_N = 1'b0; Stall = 1'b0; Flush = 1'b0; BranchTaken = 1'b0;
    BranchTarget = 32'h0; ImemReady = 1'b1; ImemRdata = 32'h0;
    cycle(); cycle();
    chk_en = 1'b1;
    chk("rst_valid", 32'(IdValid), 32'h0);
    chk("rst_instr", IdInstr, 32'h0);
    chk("rst_pc4", IdPCPlus4, 32'h0);
    chk("rst_req", 32'(ImemReq), 32'h1);
    chk("rst_addr", ImemAddr, 32'h0000_3000);

    // Back-to-back fetch
    RST_N = 1'b1;
    cycle();
    chk("seq_addr1", ImemAddr, 32'h0000_3004);
    chk("seq_pc4", IdPCPlus4, 32'h0000_3004);
    chk("seq_valid", 32'(IdValid), 32'h1);
    cycle();
    chk("seq_addr2", ImemAddr, 32'h0000_3008);

    // Stall while ori returns
    Stall = 1'b1; use_force = 1'b1; force_word = 32'h3421_FFFF;
    cycle();
    chk("stall_req", 32'(ImemReq), 32'h0);
    chk("stall_pc4", IdPCPlus4, 32'h0000_3008);
    cycle(); cycle();
    chk("stall_req3", 32'(ImemReq), 32'h0);
    Stall = 1'b0;
    cycle();
    chk("ori_instr", IdInstr, 32'h3421_FFFF);
    chk("ori_ext", 32'(ExtendType), 32'h0);
    chk("ori_imm", 32'(Immediate), 32'h0000_FFFF);
    chk("ori_pc4", IdPCPlus4, 32'h0000_300C);
    chk("ori_addr", ImemAddr, 32'h0000_300C);

    // Redirect while a request is pending
    ImemReady = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h0000_4002;
    cycle();
    chk("drain_addr1", ImemAddr, 32'h0000_300C);
    chk("drain_req", 32'(ImemReq), 32'h1);
    chk("drain_valid", 32'(IdValid), 32'h0);
    BranchTaken = 1'b0;
    cycle();
    chk("drain_addr2", ImemAddr, 32'h0000_300C);
    ImemReady = 1'b1; force_word = 32'hDEAD_BEEF;
    cycle();
    chk("redir_addr", ImemAddr, 32'h0000_4000);
    chk("drained_valid", 32'(IdValid), 32'h0);
    use_force = 1'b0;
    cycle();
    chk("redir_pc4", IdPCPlus4, 32'h0000_4004);

    // Flush alone with addi returning
    use_force = 1'b1; force_word = 32'h2008_8000; Flush = 1'b1;
    cycle();
    chk("flush_valid", 32'(IdValid), 32'h0);
    chk("flush_instr", IdInstr, 32'h0);
    chk("flush_ext", 32'(ExtendType), 32'h1);
    Flush = 1'b0;
    cycle();
    chk("addi_instr", IdInstr, 32'h2008_8000);
    chk("addi_ext", 32'(ExtendType), 32'h1);
    chk("addi_pc4", IdPCPlus4, 32'h0000_4008);

    // PC wrap
    use_force = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFE;
    cycle();
    BranchTaken = 1'b0;
    chk("wrap_addr0", ImemAddr, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_addr1", ImemAddr, 32'h0000_0000);
    chk("wrap_pc4", IdPCPlus4, 32'h0000_0000);

    // Reset during HOLD
    Stall = 1'b1;
    cycle();
    chk("hold_req", 32'(ImemReq), 32'h0);
    RST_N = 1'b0;
    cycle();
    chk("rh_valid", 32'(IdValid), 32'h0);
    chk("rh_instr", IdInstr, 32'h0);
    chk("rh_pc4", IdPCPlus4, 32'h0);
    chk("rh_req", 32'(ImemReq), 32'h1);
    chk("rh_addr", ImemAddr, 32'h0000_3000);
    RST_N = 1'b1; Stall = 1'b0;
    cycle();
    chk("rh_restart", IdPCPlus4, 32'h0000_3004);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      RST_N        = ($urandom_range(0, 299) != 0);
      BranchTaken  = ($urandom_range(0, 7) == 0);
      BranchTarget = $urandom();
      Stall        = ($urandom_range(0, 3) == 0);
      Flush        = ($urandom_range(0, 9) == 0);
      ImemReady    = ($urandom_range(0, 2) != 0);
      cycle();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
